// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared memory-interface types for the processor-side memory arbiter:
//   address/block/command/size types, the transaction tag type, the tag
//   table entry record and the default arbiter configuration.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    // Default arbiter configuration.
    localparam int NUM_MEM_CH       = 3;
    localparam int MEM_TAG_W        = 4;
    localparam int MEM_STARVE_LIMIT = 8;

    // Owner field is sized for up to 16 channels so the entry layout does
    // not depend on the channel-count parameter of any one instance.
    localparam int MEM_ARB_CH_W = 4;

    typedef logic [MEM_TAG_W-1:0] MEM_TAG;

    typedef struct packed {
        logic                    valid;
        logic [MEM_ARB_CH_W-1:0] ch_idx;
    } MEM_ARB_ENTRY;

endpackage

// File: rtl/mem_arb_picker.sv
// ---------------------------------------------------------------------------
// mem_arb_picker
//   One-hot request picker. Starved requesters are served first (lowest
//   index wins); otherwise the search starts at start_i and wraps, so a
//   start of 0 gives plain fixed priority.
//
//   req_i      in   N      request valid per channel
//   starve_i   in   N      channel has reached its starvation limit
//   start_i    in   PTR_W  first channel considered by the normal search
//   gnt_o      out  N      one-hot grant
//   gnt_idx_o  out  PTR_W  index of the granted channel
//   gnt_val_o  out  1      some channel was granted
// ---------------------------------------------------------------------------
module mem_arb_picker #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     starve_i,
    input  logic [PTR_W-1:0] start_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             gnt_val_o
);

    logic [N-1:0]   promo;
    logic [PTR_W:0] sum;
    logic [PTR_W-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        gnt_idx_o = '0;
        gnt_val_o = 1'b0;
        sum       = '0;
        cand      = '0;
        promo     = req_i & starve_i;

        if (|promo) begin
            // Walk downward so the last hit is the lowest index.
            for (int i = N - 1; i >= 0; i--) begin
                if (promo[i]) gnt_idx_o = PTR_W'(i);
            end
            gnt_val_o = 1'b1;
        end else if (|req_i) begin
            // Walk downward over offsets so the last hit is the channel
            // closest to start_i in wrap-around order.
            for (int k = N - 1; k >= 0; k--) begin
                sum = {1'b0, start_i} + (PTR_W + 1)'(k);
                if (sum >= (PTR_W + 1)'(N)) sum = sum - (PTR_W + 1)'(N);
                cand = sum[PTR_W-1:0];
                if (req_i[cand]) gnt_idx_o = cand;
            end
            gnt_val_o = 1'b1;
        end

        for (int c = 0; c < N; c++) begin
            gnt_o[c] = gnt_val_o && (gnt_idx_o == PTR_W'(c));
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   N-channel arbiter in front of a single-ported tagged main memory.
//   One request per cycle is driven onto proc2mem; accepted loads record
//   their owner in a tag table so returning data is routed back to the
//   requesting channel. Channels denied STARVE_LIMIT cycles in a row are
//   promoted above normal priority.
//
//   Build option: MEM_ARB_RR_EN -- round-robin search instead of fixed
//   priority (starvation promotion still applies first).
//
//   clock                     in   system clock
//   reset                     in   asynchronous active-low reset
//   req_val/cmd/addr/data     in   per-channel request
//   req_sent                  out  one-hot, request accepted this cycle
//   proc2mem_*                out  memory command bus (size always DOUBLE)
//   mem2proc_transaction_tag  in   nonzero = command accepted with this tag
//   mem2proc_data/_data_tag   in   returning data and its tag (0 = none)
//   resp_val/resp_data        out  routed response
//   resp_orphan               out  returning tag has no owner
//   outstanding               out  channel has a load in flight
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH       = NUM_MEM_CH,
    parameter int TAG_W        = MEM_TAG_W,
    parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_CH-1:0]  req_val,
    input  MEM_COMMAND         req_cmd  [NUM_CH],
    input  ADDR                req_addr [NUM_CH],
    input  MEM_BLOCK           req_data [NUM_CH],
    output logic [NUM_CH-1:0]  req_sent,
    output MEM_COMMAND         proc2mem_command,
    output ADDR                proc2mem_addr,
    output MEM_BLOCK           proc2mem_data,
    output MEM_SIZE            proc2mem_size,
    input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
    input  MEM_BLOCK           mem2proc_data,
    input  logic [TAG_W-1:0]   mem2proc_data_tag,
    output logic [NUM_CH-1:0]  resp_val,
    output MEM_BLOCK           resp_data,
    output logic               resp_orphan,
    output logic [NUM_CH-1:0]  outstanding
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int DEPTH = 1 << TAG_W;

    MEM_ARB_ENTRY       table_q [DEPTH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];

    logic [NUM_CH-1:0]  starve_mask;
    logic [NUM_CH-1:0]  gnt_oh;
    logic [CH_W-1:0]    win_idx;
    logic               win_val;
    logic [CH_W-1:0]    start_ptr;

    MEM_ARB_ENTRY       lookup;
    logic               accepted;
    logic               alloc_en;
    logic               free_en;

    // ---------------------------------------------------------------- grant
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            starve_mask[c] = (cnt_q[c] == CNT_W'(STARVE_LIMIT));
        end
    end

    mem_arb_picker #(
        .N     (NUM_CH),
        .PTR_W (CH_W)
    ) u_picker (
        .req_i     (req_val),
        .starve_i  (starve_mask),
        .start_i   (start_ptr),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (win_idx),
        .gnt_val_o (win_val)
    );

`ifdef MEM_ARB_RR_EN
    logic [CH_W-1:0] rr_ptr_q;
    logic [CH_W-1:0] rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accepted) begin
            rr_ptr_d = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    assign start_ptr = rr_ptr_q;
`else
    assign start_ptr = '0;
`endif

    // ------------------------------------------------------- proc2mem bus
    // Outputs are forced idle while reset is held, independent of the clock.
    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = DOUBLE;
        req_sent         = '0;
        if (reset && win_val) begin
            proc2mem_command = req_cmd[win_idx];
            proc2mem_addr    = req_addr[win_idx];
            if (req_cmd[win_idx] == MEM_STORE) proc2mem_data = req_data[win_idx];
            if (mem2proc_transaction_tag != '0) req_sent = gnt_oh;
        end
    end

    assign accepted = |req_sent;
    assign alloc_en = accepted && (proc2mem_command == MEM_LOAD);

    // ---------------------------------------------------- response routing
    assign lookup  = table_q[mem2proc_data_tag];
    assign free_en = reset && (mem2proc_data_tag != '0) && lookup.valid;

    always_comb begin
        resp_val    = '0;
        resp_orphan = 1'b0;
        resp_data   = '0;
        if (reset) begin
            resp_data = mem2proc_data;
            if (mem2proc_data_tag != '0) begin
                if (lookup.valid) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        resp_val[c] = (lookup.ch_idx == MEM_ARB_CH_W'(c));
                    end
                end else begin
                    resp_orphan = 1'b1;
                end
            end
        end
    end

    // ----------------------------------------------------------- tag table
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: this is a flop array, not a RAM; the valid bits are the
            // state, so every entry must clear on reset.
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments; when the freed tag is the one
            // being allocated, the later allocation assignment wins.
            if (free_en)  table_q[mem2proc_data_tag].valid <= 1'b0;
            if (alloc_en) table_q[mem2proc_transaction_tag] <= '{valid: 1'b1,
                                                                 ch_idx: MEM_ARB_CH_W'(win_idx)};
        end
    end

    always_comb begin
        outstanding = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (table_q[e].valid && (table_q[e].ch_idx == MEM_ARB_CH_W'(c))) begin
                    outstanding[c] = 1'b1;
                end
            end
        end
        if (!reset) outstanding = '0;
    end

    // --------------------------------------------------- starvation counters
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_val[c] && !req_sent[c]) begin
                cnt_d[c] = (cnt_q[c] == CNT_W'(STARVE_LIMIT)) ? cnt_q[c] : cnt_q[c] + 1'b1;
            end else begin
                cnt_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a vector table of single-cycle
//   cases, hand-written multi-cycle sequences, and a randomized phase
//   compared against a tag-ownership reference model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NCH = 3;
    localparam int TW  = 4;
    localparam int LIM = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NCH-1:0]  req_val;
    MEM_COMMAND      req_cmd  [NCH];
    ADDR             req_addr [NCH];
    MEM_BLOCK        req_data [NCH];
    logic [NCH-1:0]  req_sent;
    MEM_COMMAND      proc2mem_command;
    ADDR             proc2mem_addr;
    MEM_BLOCK        proc2mem_data;
    MEM_SIZE         proc2mem_size;
    logic [TW-1:0]   tt;
    MEM_BLOCK        mdata;
    logic [TW-1:0]   dtag;
    logic [NCH-1:0]  resp_val;
    MEM_BLOCK        resp_data;
    logic            resp_orphan;
    logic [NCH-1:0]  outstanding;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.NUM_CH(NCH), .TAG_W(TW), .STARVE_LIMIT(LIM)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .req_val                  (req_val),
        .req_cmd                  (req_cmd),
        .req_addr                 (req_addr),
        .req_data                 (req_data),
        .req_sent                 (req_sent),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .proc2mem_size            (proc2mem_size),
        .mem2proc_transaction_tag (tt),
        .mem2proc_data            (mdata),
        .mem2proc_data_tag        (dtag),
        .resp_val                 (resp_val),
        .resp_data                (resp_data),
        .resp_orphan              (resp_orphan),
        .outstanding              (outstanding)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req_val = '0;
        for (int c = 0; c < NCH; c++) begin
            req_cmd[c]  = MEM_NONE;
            req_addr[c] = 32'h1000 + 32'(c) * 32'h100;
            req_data[c] = 64'hD0D0_0000_0000_0000 + 64'(c);
        end
        tt    = '0;
        dtag  = '0;
        mdata = '0;
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the
    // falling edge.
    task automatic settle();
        @(negedge clock);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        logic [2:0]  val;
        MEM_COMMAND  c0, c1, c2;
        logic [3:0]  ttag;
        logic [3:0]  dt;
        MEM_COMMAND  e_cmd;
        ADDR         e_addr;
        MEM_BLOCK    e_data;
        logic [2:0]  e_sent;
        logic        e_orph;
    } vec_t;

    vec_t vecs [6];

    // ------------------------------------------------------ reference model
    bit m_valid [16];
    int m_owner [16];
    int m_cnt   [NCH];
    int m_rr;

    task automatic model_reset();
        for (int t = 0; t < 16; t++) begin
            m_valid[t] = 1'b0;
            m_owner[t] = 0;
        end
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        m_rr = 0;
    endtask

    task automatic rand_cycle();
        int win, c;
        bit acc;
        MEM_COMMAND e_cmd;
        ADDR e_addr;
        MEM_BLOCK e_data;
        logic [NCH-1:0] e_sent, e_rv, e_out;
        logic e_orph;

        for (int k = 0; k < NCH; k++) begin
            req_val[k]  = ($urandom_range(0, 3) != 0);
            req_cmd[k]  = ($urandom_range(0, 1) != 0) ? MEM_LOAD : MEM_STORE;
            req_addr[k] = $urandom;
            req_data[k] = {$urandom, $urandom};
        end
        tt    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        dtag  = 4'($urandom_range(0, 15));
        mdata = {$urandom, $urandom};

        // Starved channels first, otherwise first requester from m_rr.
        win = -1;
        for (int k = 0; k < NCH; k++) begin
            if (win < 0 && req_val[k] && m_cnt[k] == LIM) win = k;
        end
        for (int k = 0; k < NCH; k++) begin
            c = (m_rr + k) % NCH;
            if (win < 0 && req_val[c]) win = c;
        end

        e_cmd  = (win < 0) ? MEM_NONE : req_cmd[win];
        e_addr = (win < 0) ? 32'h0 : req_addr[win];
        e_data = (win >= 0 && req_cmd[win] == MEM_STORE) ? req_data[win] : 64'h0;
        acc    = (win >= 0) && (tt != 0);
        e_sent = acc ? NCH'(1 << win) : '0;
        e_rv   = '0;
        e_orph = 1'b0;
        if (dtag != 0) begin
            if (m_valid[dtag]) e_rv = NCH'(1 << m_owner[dtag]);
            else               e_orph = 1'b1;
        end
        e_out = '0;
        for (int t = 0; t < 16; t++) if (m_valid[t]) e_out[m_owner[t]] = 1'b1;

        settle();
        check("rnd_sent", 64'(req_sent), 64'(e_sent));
        check("rnd_cmd", 64'(proc2mem_command), 64'(e_cmd));
        check("rnd_addr", 64'(proc2mem_addr), 64'(e_addr));
        check("rnd_data", proc2mem_data, e_data);
        check("rnd_resp_val", 64'(resp_val), 64'(e_rv));
        check("rnd_resp_data", resp_data, mdata);
        check("rnd_orphan", 64'(resp_orphan), 64'(e_orph));
        check("rnd_outstanding", 64'(outstanding), 64'(e_out));

        // Advance the model across the edge: free first, allocation wins.
        if (dtag != 0 && m_valid[dtag]) m_valid[dtag] = 1'b0;
        if (acc && req_cmd[win] == MEM_LOAD) begin
            m_valid[tt] = 1'b1;
            m_owner[tt] = win;
        end
        for (int k = 0; k < NCH; k++) begin
            if (req_val[k] && !(acc && win == k)) m_cnt[k] = (m_cnt[k] < LIM) ? m_cnt[k] + 1 : LIM;
            else                                 m_cnt[k] = 0;
        end
`ifdef MEM_ARB_RR_EN
        if (acc) m_rr = (win + 1) % NCH;
`endif
        next();
    endtask

    initial begin
        vecs[0] = '{3'b000, MEM_NONE, MEM_NONE, MEM_NONE, 4'd0, 4'd0,
                    MEM_NONE, 32'h0, 64'h0, 3'b000, 1'b0};
        vecs[1] = '{3'b101, MEM_STORE, MEM_NONE, MEM_LOAD, 4'd3, 4'd0,
                    MEM_STORE, 32'h1000, 64'hD0D0_0000_0000_0000, 3'b001, 1'b0};
        vecs[2] = '{3'b110, MEM_NONE, MEM_LOAD, MEM_STORE, 4'd0, 4'd0,
                    MEM_LOAD, 32'h1100, 64'h0, 3'b000, 1'b0};
        vecs[3] = '{3'b100, MEM_NONE, MEM_NONE, MEM_STORE, 4'd7, 4'd0,
                    MEM_STORE, 32'h1200, 64'hD0D0_0000_0000_0002, 3'b100, 1'b0};
        vecs[4] = '{3'b010, MEM_NONE, MEM_STORE, MEM_NONE, 4'd0, 4'd9,
                    MEM_STORE, 32'h1100, 64'hD0D0_0000_0000_0001, 3'b000, 1'b1};
        vecs[5] = '{3'b011, MEM_LOAD, MEM_STORE, MEM_NONE, 4'd0, 4'd0,
                    MEM_LOAD, 32'h1000, 64'h0, 3'b000, 1'b0};

        // Reset held low with live requests: everything idle.
        clear_inputs();
        req_val = 3'b111;
        for (int c = 0; c < NCH; c++) req_cmd[c] = MEM_STORE;
        tt   = 4'd2;
        dtag = 4'd3;
        settle();
        check("rst_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
        check("rst_size", 64'(proc2mem_size), 64'(DOUBLE));
        check("rst_addr", 64'(proc2mem_addr), 64'h0);
        check("rst_data", proc2mem_data, 64'h0);
        check("rst_sent", 64'(req_sent), 64'h0);
        check("rst_resp_val", 64'(resp_val), 64'h0);
        check("rst_orphan", 64'(resp_orphan), 64'h0);
        check("rst_outstanding", 64'(outstanding), 64'h0);

        // ---------------------------------------------- vector table
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_val    = vecs[i].val;
            req_cmd[0] = vecs[i].c0;
            req_cmd[1] = vecs[i].c1;
            req_cmd[2] = vecs[i].c2;
            tt         = vecs[i].ttag;
            dtag       = vecs[i].dt;
            mdata      = 64'h1234_5678;
            settle();
            check($sformatf("vec%0d_cmd", i), 64'(proc2mem_command), 64'(vecs[i].e_cmd));
            check($sformatf("vec%0d_addr", i), 64'(proc2mem_addr), 64'(vecs[i].e_addr));
            check($sformatf("vec%0d_data", i), proc2mem_data, vecs[i].e_data);
            check($sformatf("vec%0d_sent", i), 64'(req_sent), 64'(vecs[i].e_sent));
            check($sformatf("vec%0d_orphan", i), 64'(resp_orphan), 64'(vecs[i].e_orph));
            check($sformatf("vec%0d_resp_val", i), 64'(resp_val), 64'h0);
            check($sformatf("vec%0d_outstanding", i), 64'(outstanding), 64'h0);
            next();
        end

        // ---------------------------------------------- rejection
        do_reset();
        req_val     = 3'b010;
        req_cmd[1]  = MEM_LOAD;
        req_addr[1] = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tt = (i == 2) ? 4'd5 : 4'd0;
            settle();
            check($sformatf("rej%0d_cmd", i), 64'(proc2mem_command), 64'(MEM_LOAD));
            check($sformatf("rej%0d_addr", i), 64'(proc2mem_addr), 64'h100);
            check($sformatf("rej%0d_sent", i), 64'(req_sent), (i == 2) ? 64'b010 : 64'b000);
            next();
        end
        clear_inputs();
        settle();
        check("rej_outstanding", 64'(outstanding), 64'b010);
        next();

        // ---------------------------------------------- routing
        req_val    = 3'b100;
        req_cmd[2] = MEM_LOAD;
        tt         = 4'd6;
        settle();
        check("route_alloc_sent", 64'(req_sent), 64'b100);
        next();
        clear_inputs();
        settle();
        check("route_outstanding2", 64'(outstanding), 64'b110);
        next();
        dtag  = 4'd6;
        mdata = 64'hDEAD;
        settle();
        check("route_resp_val", 64'(resp_val), 64'b100);
        check("route_resp_data", resp_data, 64'hDEAD);
        check("route_no_orphan", 64'(resp_orphan), 64'h0);
        next();
        dtag = 4'd0;
        settle();
        check("route_freed", 64'(outstanding), 64'b010);
        next();
        dtag = 4'd6;
        settle();
        check("route_stale_orphan", 64'(resp_orphan), 64'h1);
        check("route_stale_val", 64'(resp_val), 64'h0);
        next();
        dtag = 4'd9;
        settle();
        check("route_tag9_orphan", 64'(resp_orphan), 64'h1);
        next();

        // ---------------------------------------------- free/realloc
        clear_inputs();
        req_val    = 3'b010;
        req_cmd[1] = MEM_LOAD;
        tt         = 4'd4;
        settle();
        check("realloc_first_sent", 64'(req_sent), 64'b010);
        next();
        clear_inputs();
        req_val    = 3'b100;
        req_cmd[2] = MEM_LOAD;
        tt         = 4'd4;
        dtag       = 4'd4;
        mdata      = 64'hBEEF;
        settle();
        check("realloc_resp_val", 64'(resp_val), 64'b010);
        check("realloc_sent", 64'(req_sent), 64'b100);
        next();
        clear_inputs();
        dtag = 4'd4;
        settle();
        check("realloc_new_owner", 64'(resp_val), 64'b100);
        next();

        // Build three live entries: tag5->ch1, tag7->ch0, tag4->ch2.
        clear_inputs();
        req_val    = 3'b001;
        req_cmd[0] = MEM_LOAD;
        tt         = 4'd7;
        next();
        clear_inputs();
        req_val    = 3'b100;
        req_cmd[2] = MEM_LOAD;
        tt         = 4'd4;
        next();
        clear_inputs();
        settle();
        check("pre_reset_outstanding", 64'(outstanding), 64'b111);
        next();

        // ---------------------------------------------- async reset
        req_val    = 3'b001;
        req_cmd[0] = MEM_STORE;
        tt         = 4'd2;
        settle();
        check("pre_reset_sent", 64'(req_sent), 64'b001);
        #2;
        reset = 1'b0;
        #1;
        check("async_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
        check("async_sent", 64'(req_sent), 64'h0);
        check("async_addr", 64'(proc2mem_addr), 64'h0);
        check("async_outstanding", 64'(outstanding), 64'h0);
        clear_inputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
        dtag  = 4'd5;
        settle();
        check("post_reset_orphan", 64'(resp_orphan), 64'h1);
        check("post_reset_resp_val", 64'(resp_val), 64'h0);
        next();
        clear_inputs();
        req_val    = 3'b011;
        req_cmd[0] = MEM_STORE;
        req_cmd[1] = MEM_STORE;
        settle();
        check("post_reset_grant", 64'(proc2mem_addr), 64'h1000);
        next();

`ifndef MEM_ARB_RR_EN
        // ---------------------------------------------- starvation
        do_reset();
        req_val    = 3'b101;
        req_cmd[0] = MEM_STORE;
        req_cmd[2] = MEM_STORE;
        tt         = 4'd1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            settle();
            check($sformatf("starve_cyc%0d", cyc), 64'(req_sent), (cyc == 9) ? 64'b100 : 64'b001);
            next();
        end
`endif

        // ---------------------------------------------- random vs model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
